mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree, the next generation of our 4:1 mux. It selects one of CH channels of WIDTH bits each through log2(CH) stages of 2:1 selection. Each tree level is registered. A valid bit, the selected channel tag and a global hold travel with the data. An optional scan mode cycles through all channels automatically. It sits between multi-channel sources and single-lane consumers, such as an ADC channel sequencer or a debug-bus selector.

## Interface
Parameters:
- WIDTH, 8: bits per channel; ≥1.
- CH, 8: channel count; power of 2, ≥2. Local SW = log2(CH); latency L = SW.

Ports:
- clk  in  1  single clock; all registers update on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  CH*WIDTH  flattened channel inputs; channel i = x[i*WIDTH +: WIDTH].
- c  in  SW  manual channel select; used when scan_en=0.
- in_valid  in  1  the current x/c form a request to be sampled.
- scan_en  in  1  1 = internal scan counter supplies the select; 0 = manual select via c.
- hold  in  1  freezes the whole block (pipeline and scan counter) while 1.
- y  out  WIDTH  selected channel data.
- y_valid  out  1  y and y_ch are meaningful.
- y_ch  out  SW  channel index that produced y.

## Operation
- Effective select: sel = scan_en ? scan_cnt : c.
- Stage 1 pairs adjacent channels (2j, 2j+1) using sel[0], giving CH/2 registered results.
- Stage k (k=1..SW) selects with sel[k-1] and halves the lane count. Stage SW holds one lane, which drives y.
- The select bits and the full sel travel with the data so each stage uses the select captured alongside its operands. Changing c mid-flight never corrupts in-flight items.
- Each stage has a valid flag. A stage's data/select registers load only when its incoming valid=1; otherwise they keep their old value and the valid flag goes to 0. Bubbles are preserved, never compressed.
- Scan counter scan_cnt (SW bits):
  - Increments by 1 on each cycle with in_valid=1, scan_en=1, hold=0.
  - Wraps from CH-1 to 0.
  - Cleared to 0 on any cycle with scan_en=0 and hold=0.
  - The current value is used for the sample taken in the same cycle; the increment is seen by the next sample.
- hold=1: no register changes, including valids and scan_cnt. in_valid is ignored that cycle, so the request is dropped, not queued. Outputs stay static.
- Reset (rst_n=0, asynchronous): all stage data, select and valid registers clear to 0, and scan_cnt clears to 0. Thus y=0, y_valid=0, y_ch=0 immediately, without waiting for a clock edge. Reset mid-operation discards all in-flight items. The first item after release is the first in_valid sampled at an edge with rst_n=1.
- Width rules: no arithmetic on data. y is an exact copy of the chosen WIDTH-bit slice. The scan counter wraps modulo CH.

## Timing
- Latency: a request sampled at edge n appears on y/y_valid/y_ch after edge n+L-1 (L registered stages). With CH=8 this is 3 edges; with CH=2 it is 1 edge.
- Throughput: one item per cycle when hold=0. Back-to-back items emerge on consecutive cycles in input order.
- Hold: each hold cycle stretches latency by exactly one cycle per in-flight item, and y_valid stays at its pre-hold value.
- No combinational path from any input to any output.
- scan_en toggles take effect on the same edge: that cycle's sample uses c if scan_en=0, otherwise scan_cnt.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-stream with 3 items in flight → y=0, y_valid=0, y_ch=0 immediately. After release with no in_valid, y_valid stays 0.
- Manual select, CH=8, WIDTH=8: x[i]=8'hA0+i, in_valid=1 with c=5 at edge 0 → y=8'hA5, y_ch=5, y_valid=1 after edge 2. Then c=0..7 on consecutive cycles → y sequence A0..A7 with no gaps.
- Select change in flight: c=3 at edge 0, c=6 at edge 1, with x changing after edge 0 → outputs are 8'hA3 then 8'hA6, each tied to the data sampled at its own edge.
- Scan mode: scan_en=1 with 10 consecutive in_valid cycles → y_ch=0,1,…,7,0,1. Deassert scan_en for one cycle, then reassert → next y_ch=0.
- Hold: hold=1 for 4 cycles while 2 items are in flight → outputs frozen, scan_cnt unchanged. Requests offered during hold produce no output. The in-flight items resume exactly 4 cycles late.
- Bubbles plus CH=2: WIDTH=4, in_valid pattern 1,0,1 → y_valid pattern 1,0,1 with latency 1. y holds the previous value during the bubble.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined CH:1 multiplexer tree with one register stage per tree level.
// Valid, full select and a global hold travel with the data; optional auto-scan select.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  localparam int SW   = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*WIDTH-1:0] x,
  input  logic [SW-1:0]     c,
  input  logic              in_valid,
  input  logic              scan_en,
  input  logic              hold,
  output logic [WIDTH-1:0]  y,
  output logic              y_valid,
  output logic [SW-1:0]     y_ch
);

  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] sel;

  assign sel = scan_en ? scan_cnt : c;

  // NOTE: sequential state uses non-blocking assignments and a full async clear so every
  // flop settles to a known value the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!hold) begin
      if (!scan_en)      scan_cnt <= '0;
      else if (in_valid) scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Stage k halves the lane count using bit k-1 of the select captured with its operands.
  for (genvar k = 1; k <= SW; k++) begin : g_stage
    localparam int LANES = CH >> k;

    logic [2*LANES*WIDTH-1:0] src;
    logic [SW-1:0]            src_sel;
    logic                     src_vld;
    logic [LANES*WIDTH-1:0]   nxt;
    logic [LANES*WIDTH-1:0]   data;
    logic [SW-1:0]            sel_q;
    logic                     vld;

    if (k == 1) begin : g_head
      assign src     = x;
      assign src_sel = sel;
      assign src_vld = in_valid;
    end else begin : g_body
      assign src     = g_stage[k-1].data;
      assign src_sel = g_stage[k-1].sel_q;
      assign src_vld = g_stage[k-1].vld;
    end

    // NOTE: combinational outputs get a default before the loop so no latch is inferred.
    always_comb begin
      nxt = '0;
      for (int j = 0; j < LANES; j++) begin
        nxt[j*WIDTH +: WIDTH] = src_sel[k-1] ? src[(2*j+1)*WIDTH +: WIDTH]
                                             : src[(2*j)*WIDTH +: WIDTH];
      end
    end

    // Data and select load only with a valid item, so bubbles keep the last payload.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data  <= '0;
        sel_q <= '0;
        vld   <= 1'b0;
      end else if (!hold) begin
        vld <= src_vld;
        if (src_vld) begin
          data  <= nxt;
          sel_q <= src_sel;
        end
      end
    end
  end

  assign y       = g_stage[SW].data;
  assign y_valid = g_stage[SW].vld;
  assign y_ch    = g_stage[SW].sel_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: an 8x8-bit instance and a 2x4-bit instance share clk/rst_n.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] x8;
  logic [2:0]  c8;
  logic        iv8, se8, h8;
  logic [7:0]  y8;
  logic        yv8;
  logic [2:0]  ych8;

  logic [7:0]  x2;
  logic        c2;
  logic        iv2, se2, h2;
  logic [3:0]  y2;
  logic        yv2;
  logic        ych2;

  int tests = 0;
  int fails = 0;

  mux_tree_pipe #(.WIDTH(8), .CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .x(x8), .c(c8), .in_valid(iv8), .scan_en(se8),
    .hold(h8), .y(y8), .y_valid(yv8), .y_ch(ych8)
  );

  mux_tree_pipe #(.WIDTH(4), .CH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .c(c2), .in_valid(iv2), .scan_en(se2),
    .hold(h2), .y(y2), .y_valid(yv2), .y_ch(ych2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) x8[i*8 +: 8] = 8'hA0 + 8'(i);
  endtask

  task automatic test_reset();
    load_ramp();
    c8 = 3'd0; iv8 = 1'b0; se8 = 1'b0; h8 = 1'b0;
    x2 = 8'h00; c2 = 1'b0; iv2 = 1'b0; se2 = 1'b0; h2 = 1'b0;
    #12;
    tests++;
    if ({y8, yv8, ych8} !== {8'h00, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_state8: got y=%h v=%b ch=%0d want 00/0/0", y8, yv8, ych8);
    end
    tests++;
    if ({y2, yv2, ych2} !== {4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state2: got y=%h v=%b ch=%0d want 0/0/0", y2, yv2, ych2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_manual();
    c8 = 3'd5; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA5, 1'b1, 3'd5}) begin
      fails++;
      $display("FAIL manual_c5: got y=%h v=%b ch=%0d want a5/1/5", y8, yv8, ych8);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        c8 = 3'(i); iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      step();
      if (i >= 2) begin
        tests++;
        if ({y8, yv8, ych8} !== {8'hA0 + 8'(i-2), 1'b1, 3'(i-2)}) begin
          fails++;
          $display("FAIL manual_seq%0d: got y=%h v=%b ch=%0d want %h/1/%0d",
                   i-2, y8, yv8, ych8, 8'hA0 + 8'(i-2), i-2);
        end
      end
    end
  endtask

  task automatic test_select_in_flight();
    load_ramp();
    c8 = 3'd3; iv8 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) x8[i*8 +: 8] = 8'h50 + 8'(i);
    x8[6*8 +: 8] = 8'hA6;
    c8 = 3'd6;
    step();
    x8 = '0;
    c8 = 3'd1; iv8 = 1'b0;
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA3, 1'b1, 3'd3}) begin
      fails++;
      $display("FAIL inflight_first: got y=%h v=%b ch=%0d want a3/1/3", y8, yv8, ych8);
    end
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA6, 1'b1, 3'd6}) begin
      fails++;
      $display("FAIL inflight_second: got y=%h v=%b ch=%0d want a6/1/6", y8, yv8, ych8);
    end
    load_ramp();
  endtask

  task automatic test_scan();
    se8 = 1'b1; c8 = 3'd7;
    for (int i = 0; i < 12; i++) begin
      iv8 = (i < 10);
      step();
      if (i >= 2) begin
        tests++;
        if ({y8, yv8, ych8} !== {8'hA0 + 8'((i-2) % 8), 1'b1, 3'((i-2) % 8)}) begin
          fails++;
          $display("FAIL scan_seq%0d: got y=%h v=%b ch=%0d want %h/1/%0d",
                   i-2, y8, yv8, ych8, 8'hA0 + 8'((i-2) % 8), (i-2) % 8);
        end
      end
    end
    se8 = 1'b0; iv8 = 1'b0;
    step();
    se8 = 1'b1; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step();
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA0, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL scan_restart: got y=%h v=%b ch=%0d want a0/1/0", y8, yv8, ych8);
    end
  endtask

  task automatic test_hold();
    se8 = 1'b0; iv8 = 1'b0;
    step(); step(); step();
    se8 = 1'b1; iv8 = 1'b1;
    step();
    step();
    h8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({y8, yv8, ych8} !== {8'hA0, 1'b0, 3'd0}) begin
        fails++;
        $display("FAIL hold_frozen%0d: got y=%h v=%b ch=%0d want a0/0/0", i, y8, yv8, ych8);
      end
    end
    h8 = 1'b0;
    step();
    iv8 = 1'b0;
    tests++;
    if ({y8, yv8, ych8} !== {8'hA0, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL hold_resume0: got y=%h v=%b ch=%0d want a0/1/0", y8, yv8, ych8);
    end
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA1, 1'b1, 3'd1}) begin
      fails++;
      $display("FAIL hold_resume1: got y=%h v=%b ch=%0d want a1/1/1", y8, yv8, ych8);
    end
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA2, 1'b1, 3'd2}) begin
      fails++;
      $display("FAIL hold_cnt_kept: got y=%h v=%b ch=%0d want a2/1/2", y8, yv8, ych8);
    end
    step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA2, 1'b0, 3'd2}) begin
      fails++;
      $display("FAIL hold_dropped: got y=%h v=%b ch=%0d want a2/0/2", y8, yv8, ych8);
    end
    se8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    iv8 = 1'b1;
    c8 = 3'd1; step();
    c8 = 3'd2; step();
    c8 = 3'd3; step();
    tests++;
    if ({y8, yv8, ych8} !== {8'hA1, 1'b1, 3'd1}) begin
      fails++;
      $display("FAIL pre_reset: got y=%h v=%b ch=%0d want a1/1/1", y8, yv8, ych8);
    end
    #2;
    rst_n = 1'b0;
    iv8 = 1'b0;
    #1;
    tests++;
    if ({y8, yv8, ych8} !== {8'h00, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL async_reset: got y=%h v=%b ch=%0d want 00/0/0", y8, yv8, ych8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({y8, yv8, ych8} !== {8'h00, 1'b0, 3'd0}) begin
        fails++;
        $display("FAIL post_reset%0d: got y=%h v=%b ch=%0d want 00/0/0", i, y8, yv8, ych8);
      end
    end
  endtask

  task automatic test_bubbles_ch2();
    x2 = {4'h9, 4'h6};
    c2 = 1'b1; iv2 = 1'b1;
    step();
    tests++;
    if ({y2, yv2, ych2} !== {4'h9, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ch2_item0: got y=%h v=%b ch=%0d want 9/1/1", y2, yv2, ych2);
    end
    c2 = 1'b0; iv2 = 1'b0;
    step();
    tests++;
    if ({y2, yv2, ych2} !== {4'h9, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ch2_bubble: got y=%h v=%b ch=%0d want 9/0/1", y2, yv2, ych2);
    end
    iv2 = 1'b1;
    step();
    tests++;
    if ({y2, yv2, ych2} !== {4'h6, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL ch2_item1: got y=%h v=%b ch=%0d want 6/1/0", y2, yv2, ych2);
    end
    iv2 = 1'b0;
    step();
    tests++;
    if ({y2, yv2, ych2} !== {4'h6, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ch2_idle: got y=%h v=%b ch=%0d want 6/0/0", y2, yv2, ych2);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_select_in_flight();
    test_scan();
    test_hold();
    test_reset_midstream();
    test_bubbles_ch2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
